uart_msg_tx: RTL and testbench
==============================

UART_MSG_TX -- requirements
Module: uart_msg_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, clk_50M cycles per UART bit (115200 baud).
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, byte entries in the input buffer (power of 2).
REQ-003 SHALL use one clock; reset is asynchronous and active-high; ports named clk_50M and rst.
REQ-004 SHALL have port clk_50M  input  1  system clock, 50 MHz.
REQ-005 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-006 SHALL have port msg  input  8  message byte from message unit.
REQ-007 SHALL have port msg_valid  input  1  msg write strobe, one byte per high cycle.
REQ-008 SHALL have port msg_ready  output  1  buffer can accept a byte this cycle.
REQ-009 SHALL have port tx  output  1  UART serial line, idle high.
REQ-010 SHALL have port tx_busy  output  1  frame in progress.
REQ-011 SHALL have port frame_done  output  1  one-cycle pulse at end of each stop bit.
REQ-012 SHALL have port overflow  output  1  sticky flag, byte dropped on full buffer.

Function
REQ-013 SHALL frame 8N1: start bit 0, 8 data bits LSB first, one stop bit 1, each bit exactly CLKS_PER_BIT cycles.
REQ-014 SHALL write msg into the FIFO on a clock edge where msg_valid=1 and msg_ready=1; msg_ready = !full, from registered count.
REQ-015 SHALL drop msg_valid bytes while full, set overflow=1 and hold it until rst; a same-cycle pop does not rescue the dropped byte.
REQ-016 SHALL transmit every byte value including 8'h00 unchanged; content filtering belongs upstream.
REQ-017 SHALL implement FSM IDLE, START, DATA, STOP; tx_busy = (state != IDLE).
REQ-018 IDLE: if FIFO non-empty, pop head into shift register and go to START; tx=1.
REQ-019 START: tx=0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
REQ-020 DATA: tx=shift[idx]; after CLKS_PER_BIT cycles idx+1; after idx 7 go to STOP.
REQ-021 STOP: tx=1 for CLKS_PER_BIT cycles; last cycle pulses frame_done; next state START with pop if FIFO non-empty, else IDLE (no idle gap between queued bytes).
REQ-022 Latency: byte written at edge N into empty FIFO with FSM IDLE -> popped at N+1, tx falls at N+2.
REQ-023 Baud counter SHALL count 0..CLKS_PER_BIT-1, width clog2(CLKS_PER_BIT), reset to 0 on every state change.
REQ-024 FIFO read/write pointers SHALL wrap modulo FIFO_DEPTH; count width clog2(FIFO_DEPTH)+1; simultaneous push and pop when non-full and non-empty leaves count unchanged.
REQ-025 tx SHALL be driven from a flop (glitch-free).

Reset
REQ-026 On rst: tx=1, tx_busy=0, frame_done=0, overflow=0, msg_ready=1, FSM=IDLE, FIFO empty, counters 0.
REQ-027 rst mid-frame SHALL abandon the frame immediately (tx high asynchronously) and discard all buffered bytes.

Structure
REQ-028 Shared package/header uart_pkg SHALL hold FSM state encodings, CLKS_PER_BIT default and FIFO_DEPTH default.
REQ-029 Buffer SHALL be sub-module msg_fifo (sync FIFO: push, pop, din, dout, full, empty, count); FSM and baud counter live in uart_msg_tx.

Verification
REQ-030 Single byte 8'h23 ('#'), CLKS_PER_BIT=434 -> tx bits 0,1,1,0,0,0,1,0,0,1 each 434 cycles; frame_done 4340 cycles after tx falls.
REQ-031 Burst "END-#" (45,4E,44,2D,23) on 5 consecutive cycles, CLKS_PER_BIT=4 -> 50 contiguous bit periods, 5 frame_done pulses 40 cycles apart, no idle gap.
REQ-032 18 writes on consecutive cycles from idle, CLKS_PER_BIT=4 -> first 17 accepted (1 in shift reg, 16 buffered), 18th dropped, msg_ready=0, overflow=1; 17 correct frames follow.
REQ-033 rst asserted during DATA bit 3 of 8'hA5 with 3 bytes queued -> tx=1 same cycle, tx_busy=0, no further frames after rst release.
REQ-034 Push and pop same cycle at count=5 -> count stays 5, byte order preserved across pointer wrap after 40 bytes.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared state encoding and parameter defaults for the message UART transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int unsigned CLKS_PER_BIT_DEFAULT = 434;
  localparam int unsigned FIFO_DEPTH_DEFAULT   = 16;

endpackage

// File: rtl/msg_fifo.sv
// Synchronous byte FIFO with show-ahead read; pushes on full and pops on empty are ignored.
module msg_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = FIFO_DEPTH_DEFAULT,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  // Pointers are exactly log2(DEPTH) bits, so they wrap modulo DEPTH for free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_msg_tx.sv
// Buffered 8N1 UART transmitter: bytes queue in msg_fifo and leave back-to-back
// with no idle gap while the buffer stays non-empty.
module uart_msg_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int unsigned FIFO_DEPTH   = FIFO_DEPTH_DEFAULT
) (
  input  logic       clk_50M,
  input  logic       rst,
  input  logic [7:0] msg,
  input  logic       msg_valid,
  output logic       msg_ready,
  output logic       tx,
  output logic       tx_busy,
  output logic       frame_done,
  output logic       overflow
);

  localparam int unsigned BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  uart_state_e   state_q;
  logic [BW-1:0] baud_q;
  logic [2:0]    idx_q;
  logic [7:0]    shift_q;
  logic          tx_q;
  logic          tx_d;
  logic          frame_done_q;
  logic          frame_done_d;
  logic          overflow_q;

  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_pop;
  logic [7:0]    fifo_dout;
  logic [CW-1:0] fifo_count;
  logic          bit_end;

  assign bit_end  = (baud_q == BAUD_LAST);
  assign fifo_pop = !fifo_empty && ((state_q == IDLE) || (state_q == STOP && bit_end));

  msg_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk_50M),
    .rst   (rst),
    .push  (msg_valid),
    .pop   (fifo_pop),
    .din   (msg),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Line level for the current state; registered below so tx never glitches.
  always_comb begin
    tx_d = 1'b1;
    case (state_q)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_q[idx_q];
      default: tx_d = 1'b1;
    endcase
    frame_done_d = (state_q == STOP) && bit_end;
  end

  always_ff @(posedge clk_50M or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      baud_q       <= '0;
      idx_q        <= '0;
      shift_q      <= '0;
      tx_q         <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      tx_q         <= tx_d;
      frame_done_q <= frame_done_d;
      case (state_q)
        IDLE: begin
          baud_q <= '0;
          if (fifo_pop) begin
            shift_q <= fifo_dout;
            state_q <= START;
          end
        end
        START: begin
          if (bit_end) begin
            baud_q  <= '0;
            idx_q   <= '0;
            state_q <= DATA;
          end else begin
            baud_q <= baud_q + BW'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            baud_q <= '0;
            if (idx_q == 3'd7) begin
              state_q <= STOP;
            end else begin
              idx_q <= idx_q + 3'd1;
            end
          end else begin
            baud_q <= baud_q + BW'(1);
          end
        end
        STOP: begin
          if (bit_end) begin
            baud_q <= '0;
            if (fifo_pop) begin
              shift_q <= fifo_dout;
              state_q <= START;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            baud_q <= baud_q + BW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // A write on a full buffer is lost even if a pop happens on the same edge.
  always_ff @(posedge clk_50M or posedge rst) begin
    if (rst) begin
      overflow_q <= 1'b0;
    end else if (msg_valid && fifo_full) begin
      overflow_q <= 1'b1;
    end
  end

  assign msg_ready  = (fifo_count != CW'(FIFO_DEPTH));
  assign tx         = tx_q;
  assign tx_busy    = (state_q != IDLE);
  assign frame_done = frame_done_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_uart_msg_tx.sv
// Randomized self-checking bench for uart_msg_tx: a queue-based frame model predicts the
// line, handshake and status outputs every cycle, and a mid-bit UART receiver decodes tx.
module tb_uart_msg_tx;

  localparam int CPB      = 4;
  localparam int DEPTH    = 16;
  localparam int FRAME    = 10 * CPB;
  localparam int SLOW_CPB = 434;

  logic       clk_50M   = 1'b0;
  logic       rst       = 1'b1;
  logic [7:0] msg       = 8'h00;
  logic       msg_valid = 1'b0;
  logic       msg_ready, tx, tx_busy, frame_done, overflow;

  logic [7:0] msg_s       = 8'h00;
  logic       msg_valid_s = 1'b0;
  logic       msg_ready_s, tx_s, tx_busy_s, frame_done_s, overflow_s;

  int n_chk  = 0;
  int n_pass = 0;

  always #10 clk_50M = ~clk_50M;

  uart_msg_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk_50M(clk_50M), .rst(rst), .msg(msg), .msg_valid(msg_valid), .msg_ready(msg_ready),
    .tx(tx), .tx_busy(tx_busy), .frame_done(frame_done), .overflow(overflow)
  );

  uart_msg_tx dut_slow (
    .clk_50M(clk_50M), .rst(rst), .msg(msg_s), .msg_valid(msg_valid_s), .msg_ready(msg_ready_s),
    .tx(tx_s), .tx_busy(tx_busy_s), .frame_done(frame_done_s), .overflow(overflow_s)
  );

  // Reference model: a byte queue plus "cycles elapsed in current frame". The line
  // and frame_done lag the frame timeline by one registered cycle.
  logic [7:0] mq[$];
  bit         m_busy = 1'b0;
  int         m_e    = 0;
  logic [7:0] m_cur  = 8'h00;
  bit         m_ovf  = 1'b0;
  logic       exp_tx = 1'b1;
  logic       exp_fd = 1'b0;

  function automatic logic frame_bit(logic [7:0] b, int e);
    int k;
    k = e / CPB;
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return b[k-1];
  endfunction

  function automatic logic [4:0] exp_vec();
    return {exp_tx, exp_fd, m_busy, (mq.size() < DEPTH), m_ovf};
  endfunction

  initial forever begin : model_proc
    int sz;
    bit pop_now;
    @(posedge clk_50M or posedge rst);
    if (rst) begin
      mq.delete();
      m_busy = 1'b0; m_e = 0; m_ovf = 1'b0; exp_tx = 1'b1; exp_fd = 1'b0;
    end else begin
      exp_tx  = m_busy ? frame_bit(m_cur, m_e) : 1'b1;
      exp_fd  = m_busy && (m_e == FRAME - 1);
      sz      = mq.size();
      pop_now = (!m_busy || m_e == FRAME - 1) && (sz > 0);
      if (pop_now) begin
        m_cur = mq.pop_front(); m_busy = 1'b1; m_e = 0;
      end else if (m_busy) begin
        if (m_e == FRAME - 1) m_busy = 1'b0;
        else m_e++;
      end
      if (msg_valid) begin
        if (sz < DEPTH) mq.push_back(msg);
        else m_ovf = 1'b1;
      end
    end
  end

  // Mid-bit sampling receiver on the fast DUT's line.
  logic [7:0] rx_q[$];
  int         rx_ferr = 0;
  bit         rx_act  = 1'b0;
  int         rx_t    = 0;
  logic [9:0] rx_bits = '0;

  initial forever begin
    @(negedge clk_50M or posedge rst);
    if (rst) begin
      rx_act = 1'b0;
    end else if (!rx_act) begin
      if (tx === 1'b0) begin rx_act = 1'b1; rx_t = 0; end
    end else begin
      rx_t++;
      if (rx_t % CPB == CPB / 2) begin
        rx_bits[rx_t / CPB] = tx;
        if (rx_t / CPB == 9) begin
          rx_act = 1'b0;
          if (rx_bits[0] !== 1'b0 || rx_bits[9] !== 1'b1) rx_ferr++;
          rx_q.push_back(rx_bits[8:1]);
          $display("rx byte %02h", rx_bits[8:1]);
        end
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1; msg_valid = 1'b0;
    repeat (3) @(negedge clk_50M);
    n_chk++; if (tx !== 1'b1) $display("FAIL reset_tx got %b want 1", tx); else n_pass++;
    n_chk++; if (tx_busy !== 1'b0) $display("FAIL reset_busy got %b want 0", tx_busy); else n_pass++;
    n_chk++; if (frame_done !== 1'b0) $display("FAIL reset_fd got %b want 0", frame_done); else n_pass++;
    n_chk++; if (overflow !== 1'b0) $display("FAIL reset_ovf got %b want 0", overflow); else n_pass++;
    n_chk++; if (msg_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", msg_ready); else n_pass++;
    rst = 1'b0;
    @(negedge clk_50M);
    n_chk++;
    if ({tx, tx_busy, msg_ready} !== 3'b101) $display("FAIL reset_release got %b want 101", {tx, tx_busy, msg_ready});
    else n_pass++;
    $display("test_reset done");
  endtask

  task automatic test_default_baud();
    logic [9:0] frame_bits;
    int fd_t;
    int pulses;
    frame_bits = 10'b1_00100011_0;
    fd_t = -1; pulses = 0;
    @(negedge clk_50M); msg_s = 8'h23; msg_valid_s = 1'b1;
    @(negedge clk_50M); msg_valid_s = 1'b0;
    @(negedge clk_50M);
    n_chk++; if (tx_s !== 1'b1) $display("FAIL slow_prefall got %b want 1", tx_s); else n_pass++;
    @(negedge clk_50M);
    n_chk++; if (tx_s !== 1'b0) $display("FAIL slow_fall_latency got %b want 0", tx_s); else n_pass++;
    for (int t = 0; t < 10 * SLOW_CPB + 20; t++) begin
      if (t > 0) @(negedge clk_50M);
      if (frame_done_s === 1'b1) begin pulses++; fd_t = t; end
      if (t < 10 * SLOW_CPB && (t % SLOW_CPB == 0 || t % SLOW_CPB == SLOW_CPB - 1)) begin
        n_chk++;
        if (tx_s !== frame_bits[t / SLOW_CPB])
          $display("FAIL slow_bit%0d t=%0d got %b want %b", t / SLOW_CPB, t, tx_s, frame_bits[t / SLOW_CPB]);
        else n_pass++;
      end
    end
    n_chk++; if (pulses != 1) $display("FAIL slow_fd_count got %0d want 1", pulses); else n_pass++;
    n_chk++; if (fd_t != 10 * SLOW_CPB - 1) $display("FAIL slow_fd_time got %0d want %0d", fd_t, 10 * SLOW_CPB - 1); else n_pass++;
    n_chk++;
    if ({tx_s, tx_busy_s, msg_ready_s, overflow_s} !== 4'b1010)
      $display("FAIL slow_end_state got %b want 1010", {tx_s, tx_busy_s, msg_ready_s, overflow_s});
    else n_pass++;
    $display("test_default_baud: byte 23 framed, frame_done at +%0d", fd_t);
  endtask

  task automatic test_single();
    logic [7:0] b;
    logic [4:0] obs;
    int fd_t;
    b = 8'($urandom); fd_t = -1;
    rx_q.delete();
    @(negedge clk_50M); msg = b; msg_valid = 1'b1;
    @(negedge clk_50M); msg_valid = 1'b0;
    n_chk++; if ({tx, tx_busy} !== 2'b10) $display("FAIL single_after_write got %b want 10", {tx, tx_busy}); else n_pass++;
    @(negedge clk_50M);
    n_chk++; if ({tx, tx_busy} !== 2'b11) $display("FAIL single_after_pop got %b want 11", {tx, tx_busy}); else n_pass++;
    @(negedge clk_50M);
    n_chk++; if (tx !== 1'b0) $display("FAIL single_fall_latency got %b want 0", tx); else n_pass++;
    for (int c = 0; c < FRAME + 8; c++) begin
      if (c > 0) @(negedge clk_50M);
      if (frame_done === 1'b1) fd_t = c;
      obs = {tx, frame_done, tx_busy, msg_ready, overflow};
      n_chk++;
      if (obs !== exp_vec()) $display("FAIL single_wave c=%0d got %b want %b", c, obs, exp_vec());
      else n_pass++;
    end
    n_chk++; if (fd_t != FRAME - 1) $display("FAIL single_fd_time got %0d want %0d", fd_t, FRAME - 1); else n_pass++;
    n_chk++; if (rx_q.size() != 1) $display("FAIL single_rx_count got %0d want 1", rx_q.size()); else n_pass++;
    if (rx_q.size() == 1) begin
      n_chk++; if (rx_q[0] !== b) $display("FAIL single_rx_byte got %02h want %02h", rx_q[0], b); else n_pass++;
    end
    $display("test_single: sent %02h", b);
  endtask

  task automatic test_burst();
    logic [7:0] bytes [5];
    logic [4:0] obs;
    int fd_at[$];
    int busy_cycles;
    bytes = '{8'h45, 8'h4E, 8'h44, 8'h2D, 8'h23};
    busy_cycles = 0;
    rx_q.delete();
    for (int c = 0; c < 5 * FRAME + 10; c++) begin
      @(negedge clk_50M);
      obs = {tx, frame_done, tx_busy, msg_ready, overflow};
      n_chk++;
      if (obs !== exp_vec()) $display("FAIL burst_wave c=%0d got %b want %b", c, obs, exp_vec());
      else n_pass++;
      if (frame_done === 1'b1) fd_at.push_back(c);
      if (tx_busy === 1'b1) busy_cycles++;
      if (c < 5) begin msg = bytes[c]; msg_valid = 1'b1; end
      else msg_valid = 1'b0;
    end
    n_chk++; if (fd_at.size() != 5) $display("FAIL burst_fd_count got %0d want 5", fd_at.size()); else n_pass++;
    for (int i = 1; i < fd_at.size(); i++) begin
      n_chk++;
      if (fd_at[i] - fd_at[i-1] != FRAME) $display("FAIL burst_fd_gap%0d got %0d want %0d", i, fd_at[i] - fd_at[i-1], FRAME);
      else n_pass++;
    end
    n_chk++; if (busy_cycles != 5 * FRAME) $display("FAIL burst_busy_cycles got %0d want %0d", busy_cycles, 5 * FRAME); else n_pass++;
    n_chk++; if (rx_q.size() != 5) $display("FAIL burst_rx_count got %0d want 5", rx_q.size()); else n_pass++;
    for (int i = 0; i < rx_q.size() && i < 5; i++) begin
      n_chk++; if (rx_q[i] !== bytes[i]) $display("FAIL burst_rx%0d got %02h want %02h", i, rx_q[i], bytes[i]); else n_pass++;
    end
    $display("test_burst: END-# sent, %0d frames", fd_at.size());
  endtask

  task automatic test_overflow();
    logic [7:0] sent [18];
    logic [4:0] obs;
    for (int i = 0; i < 18; i++) sent[i] = 8'($urandom);
    rx_q.delete();
    for (int c = 0; c < 17 * FRAME + 12; c++) begin
      @(negedge clk_50M);
      obs = {tx, frame_done, tx_busy, msg_ready, overflow};
      n_chk++;
      if (obs !== exp_vec()) $display("FAIL ovf_wave c=%0d got %b want %b", c, obs, exp_vec());
      else n_pass++;
      if (c == 18) begin
        n_chk++; if (msg_ready !== 1'b0) $display("FAIL ovf_ready got %b want 0", msg_ready); else n_pass++;
        n_chk++; if (overflow !== 1'b1) $display("FAIL ovf_flag got %b want 1", overflow); else n_pass++;
      end
      if (c < 18) begin msg = sent[c]; msg_valid = 1'b1; end
      else msg_valid = 1'b0;
    end
    n_chk++; if (rx_q.size() != 17) $display("FAIL ovf_rx_count got %0d want 17", rx_q.size()); else n_pass++;
    for (int i = 0; i < rx_q.size() && i < 17; i++) begin
      n_chk++; if (rx_q[i] !== sent[i]) $display("FAIL ovf_rx%0d got %02h want %02h", i, rx_q[i], sent[i]); else n_pass++;
    end
    n_chk++; if (overflow !== 1'b1) $display("FAIL ovf_sticky got %b want 1", overflow); else n_pass++;
    n_chk++; if (rx_ferr != 0) $display("FAIL ovf_framing got %0d want 0", rx_ferr); else n_pass++;
    $display("test_overflow: 18 written, %0d frames out", rx_q.size());
  endtask

  task automatic test_reset_midframe();
    logic [4:0] obs;
    int lows;
    int pulses;
    lows = 0; pulses = 0;
    @(negedge clk_50M); rst = 1'b1;
    @(negedge clk_50M); rst = 1'b0;
    n_chk++; if (overflow !== 1'b0) $display("FAIL mid_ovf_cleared got %b want 0", overflow); else n_pass++;
    rx_q.delete();
    for (int c = 0; c <= 20; c++) begin
      @(negedge clk_50M);
      obs = {tx, frame_done, tx_busy, msg_ready, overflow};
      n_chk++;
      if (obs !== exp_vec()) $display("FAIL mid_wave c=%0d got %b want %b", c, obs, exp_vec());
      else n_pass++;
      if (c == 0) begin msg = 8'hA5; msg_valid = 1'b1; end
      else if (c < 4) begin msg = 8'($urandom); msg_valid = 1'b1; end
      else msg_valid = 1'b0;
    end
    n_chk++; if (tx !== 1'b0) $display("FAIL mid_bit3 got %b want 0", tx); else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_chk++; if (tx !== 1'b1) $display("FAIL mid_async_tx got %b want 1", tx); else n_pass++;
    n_chk++; if (tx_busy !== 1'b0) $display("FAIL mid_async_busy got %b want 0", tx_busy); else n_pass++;
    n_chk++;
    if ({msg_ready, frame_done} !== 2'b10) $display("FAIL mid_async_status got %b want 10", {msg_ready, frame_done});
    else n_pass++;
    @(negedge clk_50M); rst = 1'b0;
    for (int c = 0; c < 3 * FRAME; c++) begin
      @(negedge clk_50M);
      obs = {tx, frame_done, tx_busy, msg_ready, overflow};
      n_chk++;
      if (obs !== exp_vec()) $display("FAIL mid_after_wave c=%0d got %b want %b", c, obs, exp_vec());
      else n_pass++;
      if (tx !== 1'b1) lows++;
      if (frame_done === 1'b1) pulses++;
    end
    n_chk++; if (lows != 0 || pulses != 0) $display("FAIL mid_quiet got lows=%0d pulses=%0d want 0/0", lows, pulses); else n_pass++;
    n_chk++; if (rx_q.size() != 0) $display("FAIL mid_rx_count got %0d want 0", rx_q.size()); else n_pass++;
    $display("test_reset_midframe: frame abandoned, queue discarded");
  endtask

  task automatic test_wrap();
    int when[$];
    logic [7:0] sent[$];
    logic [4:0] obs;
    int wi;
    int last;
    for (int i = 0; i < 6; i++) when.push_back(i);
    when.push_back(41);
    for (int i = 0; i < 33; i++) when.push_back(when[when.size() - 1] + int'($urandom_range(30, 60)));
    last = when[when.size() - 1];
    wi = 0;
    rx_q.delete();
    for (int c = 0; c <= last + 16 * FRAME; c++) begin
      @(negedge clk_50M);
      obs = {tx, frame_done, tx_busy, msg_ready, overflow};
      n_chk++;
      if (obs !== exp_vec()) $display("FAIL wrap_wave c=%0d got %b want %b", c, obs, exp_vec());
      else n_pass++;
      n_chk++;
      if (dut.u_fifo.count !== 5'(mq.size())) $display("FAIL wrap_count c=%0d got %0d want %0d", c, dut.u_fifo.count, mq.size());
      else n_pass++;
      if (c == 42) begin
        n_chk++; if (dut.u_fifo.count !== 5'd5) $display("FAIL wrap_pushpop got %0d want 5", dut.u_fifo.count); else n_pass++;
      end
      if (wi < when.size() && when[wi] == c) begin
        msg = 8'($urandom); msg_valid = 1'b1; sent.push_back(msg); wi++;
      end else begin
        msg_valid = 1'b0;
      end
    end
    n_chk++; if (overflow !== 1'b0) $display("FAIL wrap_ovf got %b want 0", overflow); else n_pass++;
    n_chk++; if (rx_q.size() != 40) $display("FAIL wrap_rx_count got %0d want 40", rx_q.size()); else n_pass++;
    for (int i = 0; i < rx_q.size() && i < sent.size(); i++) begin
      n_chk++; if (rx_q[i] !== sent[i]) $display("FAIL wrap_rx%0d got %02h want %02h", i, rx_q[i], sent[i]); else n_pass++;
    end
    $display("test_wrap: %0d bytes through the buffer", sent.size());
  endtask

  initial begin
    test_reset();
    test_default_baud();
    test_single();
    test_burst();
    test_overflow();
    test_reset_midframe();
    test_wrap();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got no finish want finish before time limit");
    $fatal(1, "timeout");
  end

endmodule
